req_dispatch_arb: RTL and testbench
===================================

Name: req_dispatch_arb

Overview:
- Round-robin scheduler between NUM_PORTS request FIFOs and a single shared execution unit.
- Watches each FIFO head packet (req_pkt_type) and pops one FIFO per grant.
- Latches the packet into a holding register and presents it downstream with a valid/ready handshake, tagged with the source port.
- Tracks in-flight requests per port and stops granting a port when it reaches MAX_OUT outstanding.

Parameters:
NUM_PORTS, 4, number of requester FIFOs (>=2)
MAX_OUT, 2, max dispatched-but-uncompleted requests per port (1..7)
PORT_W, $clog2(NUM_PORTS), port tag width (derived)

Ports:
clk  in  1  clock, all state on rising edge
rst_b  in  1  asynchronous active-low reset
head_req  in  NUM_PORTS x req_pkt_type  FIFO head packets; head_req[p].req==1 means FIFO p non-empty
fifo_read  out  NUM_PORTS  one-cycle pop strobe per FIFO
disp_valid  out  1  dispatch packet valid
disp_ready  in  1  execution unit accepts packet
disp_pkt  out  req_pkt_type  dispatched packet
disp_port  out  PORT_W  source port of disp_pkt
resp_valid  in  1  execution unit completed one request
resp_port  in  PORT_W  port of completed request
outstanding  out  NUM_PORTS x 3  per-port in-flight count
resp_err  out  1  sticky: response for a port with zero outstanding
grant_count  out  NUM_PORTS x 16  per-port grant totals (feature-dependent)

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE; fifo_read=0; disp_valid=0; disp_pkt='0; disp_port=0.
  - All outstanding counters=0; resp_err=0; grant_count=0.
  - Round-robin pointer last=NUM_PORTS-1, so port 0 wins first.
- Eligibility: port p is eligible iff head_req[p].req==1 and outstanding[p]<MAX_OUT.
- Grant selection: first eligible port scanning last+1, last+2, ... modulo NUM_PORTS. On every grant, last <= granted port.
- Grant action, same cycle as the decision:
  - fifo_read[g]=1 for exactly one cycle.
  - Holding register <= head_req[g]; disp_port <= g.
  - outstanding[g] increments at this edge.
- fifo_read is combinational from state and eligibility. At most one bit is set per cycle.
- States:
  - IDLE: disp_valid=0. If any port is eligible: grant, go to SEND. Otherwise stay in IDLE.
  - SEND: disp_valid=1 and disp_pkt/disp_port are stable.
    - disp_ready=0: hold all outputs, no grant.
    - disp_ready=1 and a port is eligible: grant again in the same cycle and stay in SEND (back-to-back, 1 packet/cycle peak).
    - disp_ready=1 and no port is eligible: go to IDLE; disp_pkt is cleared to '0.
- Back-to-back timing: the popped FIFO presents its new head in the cycle after fifo_read. Eligibility in SEND therefore uses the updated head.
- Grant latency: head valid in IDLE -> disp_valid high next cycle.
- Responses:
  - resp_valid decrements outstanding[resp_port].
  - If the same port is granted and responded in the same cycle, its count is unchanged.
  - resp_valid for a port whose count is 0: ignored (no underflow), and resp_err is set. resp_err is sticky until reset.
  - resp_port >= NUM_PORTS: ignored, and resp_err is set.
- Credit boundary: a port at MAX_OUT is skipped. Arbitration moves to the next eligible port, with no bubble for others.
- Reset mid-SEND: the packet is dropped, counts are cleared, and there is no pop on the reset cycle.

Optional Feature:
- Macro: ARB_STATS_EN
- Defined:
  - grant_count[p] increments on each grant to p.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined:
  - grant_count tied to '0.
  - No counter flops are synthesized.
  - All other behaviour is identical.

Decomposition:
- Shared package:
  - req_pkt_type (existing).
  - Scheduler state enum {IDLE, SEND}.
  - Constants NUM_PORTS_DEF=4 and MAX_OUT_DEF=2.
- Sub-module rr_picker: combinational round-robin find-first.
  - Inputs: eligible vector, last pointer.
  - Outputs: grant valid, grant index.
  - Instantiated once.
- Credit counters and FSM stay in the top module.

Test Plan:
- Single request: port 2 head valid, others empty, disp_ready=1 -> fifo_read=4'b0100 for 1 cycle; next cycle disp_valid=1, disp_port=2, disp_pkt equals the head; outstanding[2]=1.
- Round-robin fairness: all 4 heads valid, disp_ready=1, deep FIFOs, resp_valid fires 1 cycle after each dispatch -> grant order 0,1,2,3,0,1... with disp_valid high every cycle after the first.
- Backpressure: disp_ready=0 for 5 cycles in SEND -> disp_pkt/disp_port stable, fifo_read=0; ready=1 -> next grant issued that cycle.
- Credit limit: MAX_OUT=2, port 0 only, no responses -> exactly 2 grants, then IDLE. One resp_valid/resp_port=0 -> third grant next cycle.
- Error and simultaneity: resp for port 3 with outstanding=0 -> resp_err=1, count stays 0. Grant and response to port 1 in the same cycle -> outstanding[1] unchanged.
- ARB_STATS_EN: 70000 grants to port 0 -> grant_count[0]=16'hFFFF. Without the macro -> grant_count stays 0.

Source files
------------

// File: rtl/req_dispatch_arb_pkg.sv
// ---------------------------------------------------------------------------
// req_dispatch_arb_pkg
// Shared types and defaults for the request dispatch arbiter:
//   - req_pkt_type  : FIFO head / dispatched packet (req = FIFO non-empty)
//   - sched_state_e : dispatch scheduler states
//   - NUM_PORTS_DEF / MAX_OUT_DEF : default port count and per-port credits
// ---------------------------------------------------------------------------
package req_dispatch_arb_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int MAX_OUT_DEF   = 2;

  typedef struct packed {
    logic        req;
    logic [3:0]  opcode;
    logic [7:0]  tag;
    logic [15:0] data;
  } req_pkt_type;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

endpackage

// File: rtl/req_dispatch_arb_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin find-first. Scans last+1, last+2, ... modulo
// NUM_PORTS and reports the first eligible port.
// Ports:
//   i_eligible : per-port eligibility vector
//   i_last     : most recently granted port
//   o_valid    : at least one port is eligible
//   o_idx      : index of the winning port (0 when o_valid is low)
// ---------------------------------------------------------------------------
module rr_picker
  import req_dispatch_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_eligible,
  input  logic [PORT_W-1:0]    i_last,
  output logic                 o_valid,
  output logic [PORT_W-1:0]    o_idx
);

  // The last port is visited at offset NUM_PORTS, so it only wins when
  // nobody else is eligible.
  always_comb begin
    int cand;
    o_valid = 1'b0;
    o_idx   = '0;
    cand    = 0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = (int'(i_last) + off) % NUM_PORTS;
      if (!o_valid && i_eligible[cand]) begin
        o_valid = 1'b1;
        o_idx   = PORT_W'(cand);
      end
    end
  end

endmodule

// File: rtl/req_dispatch_arb.sv
// ---------------------------------------------------------------------------
// req_dispatch_arb
// Round-robin scheduler between NUM_PORTS request FIFOs and one shared
// execution unit. Pops one FIFO per grant, holds the packet in a register
// and presents it with a valid/ready handshake tagged with its source port.
// Per-port credit counters stop granting a port at MAX_OUT in-flight.
//
// Optional feature macro: ARB_STATS_EN (per-port saturating grant counters;
// when undefined grant_count is tied to zero and no counter flops exist).
//
// Ports:
//   clk, rst_b   : clock, asynchronous active-low reset
//   head_req     : FIFO head packets (req=1 means FIFO non-empty)
//   fifo_read    : one-cycle pop strobe per FIFO (combinational)
//   disp_valid   : dispatch packet valid
//   disp_ready   : execution unit accepts the packet
//   disp_pkt     : dispatched packet
//   disp_port    : source port of disp_pkt
//   resp_valid   : execution unit completed one request
//   resp_port    : port of the completed request
//   outstanding  : per-port in-flight count
//   resp_err     : sticky, response for an idle or nonexistent port
//   grant_count  : per-port grant totals (ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module req_dispatch_arb
  import req_dispatch_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int MAX_OUT   = MAX_OUT_DEF,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  req_pkt_type [NUM_PORTS-1:0] head_req,
  output logic [NUM_PORTS-1:0]        fifo_read,
  output logic                        disp_valid,
  input  logic                        disp_ready,
  output req_pkt_type                 disp_pkt,
  output logic [PORT_W-1:0]           disp_port,
  input  logic                        resp_valid,
  input  logic [PORT_W-1:0]           resp_port,
  output logic [NUM_PORTS-1:0][2:0]   outstanding,
  output logic                        resp_err,
  output logic [NUM_PORTS-1:0][15:0]  grant_count
);

  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

  sched_state_e                r_state;
  logic                        r_dispValid;
  req_pkt_type                 r_dispPkt;
  logic [PORT_W-1:0]           r_dispPort;
  logic [PORT_W-1:0]           r_last;
  logic [NUM_PORTS-1:0][2:0]   r_outstanding;
  logic                        r_respErr;

  logic [NUM_PORTS-1:0]        w_eligible;
  logic [NUM_PORTS-1:0]        w_respHit;
  logic                        w_respInRange;
  logic                        w_respZero;
  logic                        w_gntValid;
  logic [PORT_W-1:0]           w_gntIdx;
  logic                        w_doGrant;

  // Eligibility and response decode. A response only counts as in range
  // when it matches a real port index.
  always_comb begin
    w_eligible    = '0;
    w_respHit     = '0;
    w_respInRange = 1'b0;
    w_respZero    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_eligible[p] = head_req[p].req && (r_outstanding[p] < MAX_OUT_C);
      w_respHit[p]  = resp_valid && (resp_port == PORT_W'(p));
      if (w_respHit[p]) begin
        w_respInRange = 1'b1;
        if (r_outstanding[p] == 3'd0) begin
          w_respZero = 1'b1;
        end
      end
    end
  end

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_valid    (w_gntValid),
    .o_idx      (w_gntIdx)
  );

  // IDLE always accepts a grant; SEND only when the current packet leaves.
  // Gating on rst_b keeps a held-in-reset arbiter from popping a FIFO.
  assign w_doGrant = rst_b && w_gntValid && ((r_state == IDLE) || disp_ready);

  always_comb begin
    fifo_read = '0;
    if (w_doGrant) begin
      fifo_read[w_gntIdx] = 1'b1;
    end
  end

  // Scheduler FSM and holding register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= IDLE;
      r_dispValid <= 1'b0;
      r_dispPkt   <= '0;
      r_dispPort  <= '0;
      r_last      <= PORT_W'(NUM_PORTS - 1);
    end else if (w_doGrant) begin
      r_state     <= SEND;
      r_dispValid <= 1'b1;
      r_dispPkt   <= head_req[w_gntIdx];
      r_dispPort  <= w_gntIdx;
      r_last      <= w_gntIdx;
    end else if ((r_state == SEND) && disp_ready) begin
      r_state     <= IDLE;
      r_dispValid <= 1'b0;
      r_dispPkt   <= '0;
    end
  end

  // Credit counters: a grant and a response to the same port cancel out;
  // a response to an empty counter is dropped.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_outstanding <= '0;
      r_respErr     <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case ({fifo_read[p], w_respHit[p] && (r_outstanding[p] != 3'd0)})
          2'b10:   r_outstanding[p] <= r_outstanding[p] + 3'd1;
          2'b01:   r_outstanding[p] <= r_outstanding[p] - 3'd1;
          default: r_outstanding[p] <= r_outstanding[p];
        endcase
      end
      if (resp_valid && (!w_respInRange || w_respZero)) begin
        r_respErr <= 1'b1;
      end
    end
  end

  assign disp_valid  = r_dispValid;
  assign disp_pkt    = r_dispPkt;
  assign disp_port   = r_dispPort;
  assign outstanding = r_outstanding;
  assign resp_err    = r_respErr;

`ifdef ARB_STATS_EN
  logic [NUM_PORTS-1:0][15:0] r_grantCount;

  // Saturating per-port grant totals.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_grantCount <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (fifo_read[p] && (r_grantCount[p] != 16'hFFFF)) begin
          r_grantCount[p] <= r_grantCount[p] + 16'd1;
        end
      end
    end
  end

  assign grant_count = r_grantCount;
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_req_dispatch_arb.sv
// ---------------------------------------------------------------------------
// tb_req_dispatch_arb
// Directed bench for req_dispatch_arb. Behavioural FIFOs sit behind head_req;
// expected dispatches go into a queue that a monitor drains on every
// accepted handshake.
// ---------------------------------------------------------------------------
module tb_req_dispatch_arb;
  import req_dispatch_arb_pkg::*;

  localparam int NP = 4;

  logic                   clk = 1'b0;
  logic                   rst_b = 1'b0;
  req_pkt_type [NP-1:0]   head_req;
  logic [NP-1:0]          fifo_read;
  logic                   disp_valid;
  logic                   disp_ready;
  req_pkt_type            disp_pkt;
  logic [1:0]             disp_port;
  logic                   resp_valid;
  logic [1:0]             resp_port;
  logic [NP-1:0][2:0]     outstanding;
  logic                   resp_err;
  logic [NP-1:0][15:0]    grant_count;

  int vectors = 0;
  int miscompares = 0;

  logic [NP-1:0]  autoFill;
  req_pkt_type    mem [NP][16];
  int             wr [NP];
  int             rd [NP];
  logic           manRespV;
  logic [1:0]     manRespPort;
  logic           autoResp;
  logic           autoRespV;
  logic [1:0]     autoRespPort;

  typedef struct packed {
    logic [1:0]  port;
    req_pkt_type pkt;
  } exp_t;

  exp_t expQ[$];

  req_dispatch_arb dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .head_req    (head_req),
    .fifo_read   (fifo_read),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_pkt    (disp_pkt),
    .disp_port   (disp_port),
    .resp_valid  (resp_valid),
    .resp_port   (resp_port),
    .outstanding (outstanding),
    .resp_err    (resp_err),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  function automatic req_pkt_type mkPkt(input int p, input int k);
    req_pkt_type r;
    r.req    = 1'b1;
    r.opcode = 4'(p);
    r.tag    = 8'(k);
    r.data   = 16'(32'hA000 + k);
    return r;
  endfunction

  // Head of each behavioural FIFO: endless stream when autoFill is set,
  // otherwise the manually loaded entries.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      if (autoFill[p]) begin
        head_req[p] = mkPkt(p, rd[p]);
      end else if (wr[p] != rd[p]) begin
        head_req[p] = mem[p][rd[p] % 16];
      end else begin
        head_req[p] = '0;
      end
    end
  end

  // Pops follow the strobe seen before the edge.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (!rst_b) begin
        rd[p] <= 0;
      end else if (fifo_read[p]) begin
        rd[p] <= rd[p] + 1;
      end
    end
  end

  // Execution unit stand-in: answers one cycle after each accepted packet.
  always @(posedge clk) begin
    if (!rst_b) begin
      autoRespV    <= 1'b0;
      autoRespPort <= 2'd0;
    end else begin
      autoRespV    <= autoResp && disp_valid && disp_ready;
      autoRespPort <= disp_port;
    end
  end

  assign resp_valid = manRespV | autoRespV;
  assign resp_port  = autoRespV ? autoRespPort : manRespPort;

  // Scoreboard monitor: every accepted handshake must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b && disp_valid && disp_ready) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected: got port %0d pkt %h, required no dispatch", disp_port, disp_pkt);
      end else begin
        e = expQ.pop_front();
        if ((e.port !== disp_port) || (e.pkt !== disp_pkt)) begin
          miscompares++;
          $display("[TB] FAIL sb_dispatch: got port %0d pkt %h, required port %0d pkt %h",
                   disp_port, disp_pkt, e.port, e.pkt);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [NP-1:0] fill,
                               input logic rv, input logic [1:0] rp);
    disp_ready  = ready;
    autoFill    = fill;
    manRespV    = rv;
    manRespPort = rp;
  endtask

  task automatic pushExp(input int p, input req_pkt_type pkt);
    exp_t e;
    e.port = 2'(p);
    e.pkt  = pkt;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0, 2'd0);
    autoResp = 1'b0;
    rst_b    = 1'b0;
    for (int p = 0; p < NP; p++) wr[p] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    req_pkt_type pkt;
    for (int p = 0; p < NP; p++) begin
      wr[p] = 0;
      for (int i = 0; i < 16; i++) mem[p][i] = '0;
    end
    applyStimulus(1'b0, '0, 1'b0, 2'd0);
    autoResp = 1'b0;

    // Reset state
    $display("[TB] reset state");
    doReset();
    checkOutput("rst_valid", 32'(disp_valid), 32'd0);
    checkOutput("rst_pkt", 32'(disp_pkt), 32'd0);
    checkOutput("rst_port", 32'(disp_port), 32'd0);
    checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
    checkOutput("rst_err", 32'(resp_err), 32'd0);
    checkOutput("rst_fifo_read", 32'(fifo_read), 32'd0);
    checkOutput("rst_grant_count", 32'(grant_count != '0), 32'd0);

    // Single request on port 2
    $display("[TB] single request");
    pkt = mkPkt(2, 32'h5A);
    mem[2][0] = pkt;
    wr[2] = 1;
    pushExp(2, pkt);
    applyStimulus(1'b1, '0, 1'b0, 2'd0);
    #1;
    checkOutput("single_pop", 32'(fifo_read), 32'h4);
    tick();
    checkOutput("single_valid", 32'(disp_valid), 32'd1);
    checkOutput("single_port", 32'(disp_port), 32'd2);
    checkOutput("single_pkt", 32'(disp_pkt), 32'(pkt));
    checkOutput("single_out2", 32'(outstanding[2]), 32'd1);
    checkOutput("single_pop_once", 32'(fifo_read), 32'd0);
    tick();
    checkOutput("single_idle", 32'(disp_valid), 32'd0);
    checkOutput("single_pkt_clr", 32'(disp_pkt), 32'd0);

    // Round-robin fairness with a prompt execution unit
    $display("[TB] round robin");
    doReset();
    autoResp = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) pushExp(p, mkPkt(p, k));
    applyStimulus(1'b1, 4'hF, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("rr_valid", 32'(disp_valid), 32'd1);
    end
    applyStimulus(1'b1, '0, 1'b0, 2'd0);
    tick();
    tick();
    checkOutput("rr_drained", 32'(outstanding), 32'd0);
    checkOutput("rr_idle", 32'(disp_valid), 32'd0);

    // Backpressure holds the packet and blocks further grants
    $display("[TB] backpressure");
    doReset();
    pushExp(1, mkPkt(1, 0));
    pushExp(3, mkPkt(3, 0));
    applyStimulus(1'b0, 4'b1010, 1'b0, 2'd0);
    #1;
    checkOutput("bp_idle_pop", 32'(fifo_read), 32'h2);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_port", 32'(disp_port), 32'd1);
      checkOutput("bp_pkt", 32'(disp_pkt), 32'(mkPkt(1, 0)));
      checkOutput("bp_no_pop", 32'(fifo_read), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 4'b1010, 1'b0, 2'd0);
    #1;
    checkOutput("bp_release_pop", 32'(fifo_read), 32'h8);
    tick();
    applyStimulus(1'b1, '0, 1'b0, 2'd0);
    tick();
    checkOutput("bp_idle", 32'(disp_valid), 32'd0);
    checkOutput("bp_out1", 32'(outstanding[1]), 32'd1);
    checkOutput("bp_out3", 32'(outstanding[3]), 32'd1);

    // Credit limit on a single port
    $display("[TB] credit limit");
    doReset();
    for (int k = 0; k < 3; k++) pushExp(0, mkPkt(0, k));
    applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0);
    tick();
    tick();
    tick();
    checkOutput("cr_idle", 32'(disp_valid), 32'd0);
    checkOutput("cr_out0", 32'(outstanding[0]), 32'd2);
    checkOutput("cr_no_pop", 32'(fifo_read), 32'd0);
    tick();
    checkOutput("cr_still_idle", 32'(disp_valid), 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b1, 2'd0);
    tick();
    applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0);
    #1;
    checkOutput("cr_pop_after_resp", 32'(fifo_read), 32'h1);
    checkOutput("cr_out0_dec", 32'(outstanding[0]), 32'd1);
    checkOutput("cr_no_err", 32'(resp_err), 32'd0);
    tick();
    checkOutput("cr_third_valid", 32'(disp_valid), 32'd1);
    checkOutput("cr_third_pkt", 32'(disp_pkt), 32'(mkPkt(0, 2)));
    applyStimulus(1'b1, '0, 1'b0, 2'd0);
    tick();

    // Reset while a packet is held
    $display("[TB] reset mid-send");
    doReset();
    applyStimulus(1'b0, 4'b0100, 1'b0, 2'd0);
    tick();
    checkOutput("rms_valid", 32'(disp_valid), 32'd1);
    rst_b = 1'b0;
    #1;
    checkOutput("rms_no_pop", 32'(fifo_read), 32'd0);
    checkOutput("rms_dropped", 32'(disp_valid), 32'd0);
    checkOutput("rms_counts", 32'(outstanding), 32'd0);

    // Error response and simultaneous grant/response
    $display("[TB] error and simultaneity");
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 2'd3);
    tick();
    checkOutput("err_set", 32'(resp_err), 32'd1);
    checkOutput("err_out3", 32'(outstanding[3]), 32'd0);
    pushExp(1, mkPkt(1, 0));
    pushExp(1, mkPkt(1, 1));
    applyStimulus(1'b1, 4'b0010, 1'b0, 2'd0);
    tick();
    checkOutput("sim_out1_first", 32'(outstanding[1]), 32'd1);
    applyStimulus(1'b1, 4'b0010, 1'b1, 2'd1);
    tick();
    checkOutput("sim_out1_same", 32'(outstanding[1]), 32'd1);
    checkOutput("sim_pkt", 32'(disp_pkt), 32'(mkPkt(1, 1)));
    applyStimulus(1'b1, '0, 1'b0, 2'd0);
    tick();
    checkOutput("err_sticky", 32'(resp_err), 32'd1);
    checkOutput("sim_out1_end", 32'(outstanding[1]), 32'd1);
`ifdef ARB_STATS_EN
    checkOutput("stats_gc1", 32'(grant_count[1]), 32'd2);
`else
    checkOutput("stats_gc1_off", 32'(grant_count[1]), 32'd0);
`endif
    checkOutput("stats_gc0", 32'(grant_count[0]), 32'd0);

`ifdef ARB_STATS_EN
    // Saturation of the grant counter
    $display("[TB] grant counter saturation");
    doReset();
    for (int k = 0; k < 70000; k++) pushExp(0, mkPkt(0, k));
    applyStimulus(1'b1, 4'b0001, 1'b1, 2'd0);
    repeat (70000) tick();
    applyStimulus(1'b1, '0, 1'b0, 2'd0);
    tick();
    checkOutput("stats_sat", 32'(grant_count[0]), 32'h0000FFFF);
    checkOutput("stats_other", 32'(grant_count[1]), 32'd0);
`endif

    tick();
    checkOutput("sb_drain", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
